// File: rtl/qsn_inv_ctrl_len15.sv
// Inverse-rotation select controller for a length-15 QSN: buffers forward shift factors in a
// FIFO and, on each return request, emits registered left/right/merge selects for the inverse.
module qsn_inv_ctrl_len15 #(
   parameter int unsigned PERMUTATION_LENGTH = 15,
   parameter int unsigned FIFO_DEPTH         = 8
) (
   input  logic        sys_clk,
   input  logic        rstn,
   input  logic        flush,
   input  logic [3:0]  fwd_shift_factor,
   input  logic        fwd_valid,
   output logic        fwd_ready,
   input  logic        ret_req,
   output logic [3:0]  left_sel,
   output logic [3:0]  right_sel,
   output logic [13:0] merge_sel,
   output logic        sel_valid,
   output logic [3:0]  fifo_count,
   output logic        underflow_err,
   output logic        range_err
);

   localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [3:0]  PermLen = 4'(PERMUTATION_LENGTH);
   localparam logic [3:0]  Depth   = 4'(FIFO_DEPTH);

   logic [3:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [3:0]      count_q;
   logic            push, pop, empty, full;
   logic [3:0]      wr_val, rd_val, inv;
   logic [3:0]      left_d, right_d;
   logic [13:0]     merge_d;

   always_comb begin
      empty  = (count_q == 4'd0);
      full   = (count_q == Depth);
      // flush wins over both FIFO operations
      push   = fwd_valid && !full && !flush;
      pop    = ret_req && !empty && !flush;
      wr_val = (fwd_shift_factor == PermLen) ? 4'd0 : fwd_shift_factor;
      rd_val = mem_q[rptr_q];
      inv    = (rd_val == 4'd0) ? 4'd0 : PermLen - rd_val;
      left_d = inv;
      right_d = (inv != 4'd0) ? PermLen - inv : 4'd0;
      merge_d = '0;
      if (inv != 4'd0 && inv < PermLen) begin
         merge_d = 14'((15'd1 << (PermLen - inv)) - 15'd1);
      end
   end

   assign fwd_ready  = !full;
   assign fifo_count = count_q;

   // Storage is not reset: entries are only ever read below count_q.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_val;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= 4'd0;
         sel_valid     <= 1'b0;
         left_sel      <= 4'd0;
         right_sel     <= 4'd0;
         merge_sel     <= 14'd0;
         underflow_err <= 1'b0;
         range_err     <= 1'b0;
      end else begin
         sel_valid <= pop;
         if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= 4'd0;
         end else begin
            if (push) begin
               wptr_q <= wptr_q + PtrW'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
               count_q <= count_q + 4'd1;
            end else if (pop && !push) begin
               count_q <= count_q - 4'd1;
            end
            if (ret_req && empty) begin
               underflow_err <= 1'b1;
            end
            if (push && fwd_shift_factor == PermLen) begin
               range_err <= 1'b1;
            end
         end
         if (pop) begin
            left_sel  <= left_d;
            right_sel <= right_d;
            merge_sel <= merge_d;
         end
      end
   end

endmodule

// File: tb/tb_qsn_inv_ctrl_len15.sv
// Self-checking bench for qsn_inv_ctrl_len15: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_qsn_inv_ctrl_len15;

   localparam int DEPTH = 8;

   logic        sys_clk = 1'b0;
   logic        rstn = 1'b1;
   logic        flush = 1'b0;
   logic [3:0]  fwd_shift_factor = 4'd0;
   logic        fwd_valid = 1'b0;
   logic        ret_req = 1'b0;
   logic        fwd_ready;
   logic [3:0]  left_sel, right_sel, fifo_count;
   logic [13:0] merge_sel;
   logic        sel_valid, underflow_err, range_err;

   qsn_inv_ctrl_len15 #(.PERMUTATION_LENGTH(15), .FIFO_DEPTH(DEPTH)) dut (
      .sys_clk          (sys_clk),
      .rstn             (rstn),
      .flush            (flush),
      .fwd_shift_factor (fwd_shift_factor),
      .fwd_valid        (fwd_valid),
      .fwd_ready        (fwd_ready),
      .ret_req          (ret_req),
      .left_sel         (left_sel),
      .right_sel        (right_sel),
      .merge_sel        (merge_sel),
      .sel_valid        (sel_valid),
      .fifo_count       (fifo_count),
      .underflow_err    (underflow_err),
      .range_err        (range_err)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad = 0;

   // reference model state
   int          q[$];
   int          m_left, m_right, m_merge;
   logic        m_valid, m_uf, m_re;

   typedef struct {
      logic [3:0]  s;
      logic [3:0]  l;
      logic [3:0]  r;
      logic [13:0] m;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_left = 0; m_right = 0; m_merge = 0;
      m_valid = 1'b0; m_uf = 1'b0; m_re = 1'b0;
   endtask

   // One clock with the given inputs; model predicts, then every output is compared.
   task automatic cycle(input logic v, input logic [3:0] f, input logic r, input logic fl);
      int  s, inv, sz;
      logic pu, po;
      fwd_valid = v; fwd_shift_factor = f; ret_req = r; flush = fl;
      sz = q.size();
      pu = v && (sz != DEPTH) && !fl;
      po = r && (sz != 0) && !fl;
      m_valid = po;
      if (!fl && r && sz == 0) m_uf = 1'b1;
      if (fl) q.delete();
      if (po) begin
         s = q.pop_front();
         inv = (s == 0) ? 0 : 15 - s;
         m_left  = inv;
         m_right = (inv != 0) ? 15 - inv : 0;
         m_merge = (inv != 0) ? (1 << (15 - inv)) - 1 : 0;
      end
      if (pu) begin
         q.push_back((f == 4'd15) ? 0 : int'(f));
         if (f == 4'd15) m_re = 1'b1;
      end
      @(posedge sys_clk);
      #1;
      check("fifo_count", 32'(fifo_count), 32'(q.size()));
      check("fwd_ready", 32'(fwd_ready), 32'(q.size() != DEPTH));
      check("sel_valid", 32'(sel_valid), 32'(m_valid));
      check("left_sel", 32'(left_sel), 32'(m_left));
      check("right_sel", 32'(right_sel), 32'(m_right));
      check("merge_sel", 32'(merge_sel), 32'(m_merge));
      check("underflow_err", 32'(underflow_err), 32'(m_uf));
      check("range_err", 32'(range_err), 32'(m_re));
      fwd_valid = 1'b0; ret_req = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ready", 32'(fwd_ready), 32'd1);
      check("rst_valid", 32'(sel_valid), 32'd0);
      check("rst_sels", {left_sel, right_sel, merge_sel}, 32'd0);
      check("rst_errs", {underflow_err, range_err}, 32'd0);
      model_reset();
      @(negedge sys_clk);
      rstn = 1'b1;
   endtask

   initial begin
      tbl[0] = '{s: 4'd1,  l: 4'd14, r: 4'd1,  m: 14'h0001};
      tbl[1] = '{s: 4'd14, l: 4'd1,  r: 4'd14, m: 14'h3FFF};
      tbl[2] = '{s: 4'd0,  l: 4'd0,  r: 4'd0,  m: 14'h0000};
      tbl[3] = '{s: 4'd3,  l: 4'd12, r: 4'd3,  m: 14'h0007};
      tbl[4] = '{s: 4'd15, l: 4'd0,  r: 4'd0,  m: 14'h0000};
      tbl[5] = '{s: 4'd7,  l: 4'd8,  r: 4'd7,  m: 14'h007F};
      model_reset();
      #2;
      do_reset();

      // Underflow on empty, sticky across a later push
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
      check("uf_set", 32'(underflow_err), 32'd1);
      check("uf_no_valid", 32'(sel_valid), 32'd0);
      cycle(1'b1, 4'd5, 1'b0, 1'b0);
      check("uf_sticky", 32'(underflow_err), 32'd1);
      cycle(1'b0, 4'd0, 1'b1, 1'b0);

      // Table of shift factors and their inverse selects
      for (int i = 0; i < 6; i++) cycle(1'b1, tbl[i].s, 1'b0, 1'b0);
      check("range_set", 32'(range_err), 32'd1);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 4'd0, 1'b1, 1'b0);
         check("tbl_valid", 32'(sel_valid), 32'd1);
         check("tbl_left", 32'(left_sel), 32'(tbl[i].l));
         check("tbl_right", 32'(right_sel), 32'(tbl[i].r));
         check("tbl_merge", 32'(merge_sel), 32'(tbl[i].m));
      end
      cycle(1'b0, 4'd0, 1'b0, 1'b0);
      check("sel_hold_left", 32'(left_sel), 32'd8);

      // Fill to full, ignored 9th push, pop frees one slot
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 2), 1'b0, 1'b0);
      check("full_count", 32'(fifo_count), 32'd8);
      check("full_ready", 32'(fwd_ready), 32'd0);
      cycle(1'b1, 4'd9, 1'b0, 1'b0);
      check("full_ignore", 32'(fifo_count), 32'd8);
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
      check("pop_count", 32'(fifo_count), 32'd7);
      check("pop_ready", 32'(fwd_ready), 32'd1);

      // Simultaneous push/pop at 4, then flush and underflow
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
      cycle(1'b1, 4'd6, 1'b1, 1'b0);
      check("pushpop_count", 32'(fifo_count), 32'd4);
      cycle(1'b1, 4'd15, 1'b1, 1'b1);
      check("flush_count", 32'(fifo_count), 32'd0);
      check("flush_valid", 32'(sel_valid), 32'd0);
      check("flush_no_range", 32'(range_err), 32'd0);
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
      check("flush_uf", 32'(underflow_err), 32'd1);

      // No bypass: push into empty plus pop in same cycle
      cycle(1'b1, 4'd4, 1'b1, 1'b0);
      check("nobypass_valid", 32'(sel_valid), 32'd0);
      check("nobypass_count", 32'(fifo_count), 32'd1);

      // Async reset with entries buffered and a pop in flight
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 9), 1'b0, 1'b0);
      cycle(1'b0, 4'd0, 1'b1, 1'b0);
      ret_req = 1'b1;
      #1;
      do_reset();
      ret_req = 1'b0;

      // Random traffic against the model
      for (int n = 0; n < 500; n++) begin
         cycle(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
